// File: rtl/mymem_pkg.sv
// Shared widths, controller state encoding and burst command record for the
// scratch-memory burst master.
package mymem_pkg;

  localparam int MYMEM_ADDR_W     = 10;
  localparam int MYMEM_DATA_W     = 64;
  localparam int MYMEM_TAG_W      = 5;
  localparam int MYMEM_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic                    write;
    logic [MYMEM_ADDR_W-1:0] base;
    logic [MYMEM_ADDR_W:0]   len;
  } cmd_t;

  // Word address of the offset-th beat; wraps at the top of the memory.
  function automatic logic [MYMEM_ADDR_W-1:0] wrap_addr(
    input logic [MYMEM_ADDR_W-1:0] base,
    input logic [MYMEM_ADDR_W-1:0] offset
  );
    return base + offset;
  endfunction

endpackage

// File: rtl/mymem_burst_master_if.sv
// Command, stream and memory request/response signals of the burst master.
// The master modport is the controller view; slave is the decoder/memory side.
interface mymem_burst_master_if
  import mymem_pkg::*;
#(
  parameter int ADDR_W = MYMEM_ADDR_W,
  parameter int DATA_W = MYMEM_DATA_W,
  parameter int TAG_W  = MYMEM_TAG_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic              busy;
  logic              done;
  logic              tag_err;

  logic              mem_rqvalid;
  logic [TAG_W-1:0]  mem_rqaddr;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wrdata;
  logic              mem_rdvalid;
  logic [TAG_W-1:0]  mem_rdaddr;
  logic [DATA_W-1:0] mem_rddata;

  modport master (
    input  cmd_valid, cmd_write, cmd_base, cmd_len,
    input  wr_valid, wr_data, rd_ready,
    input  mem_rdvalid, mem_rdaddr, mem_rddata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output busy, done, tag_err,
    output mem_rqvalid, mem_rqaddr, mem_wren, mem_addr, mem_wrdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_base, cmd_len,
    output wr_valid, wr_data, rd_ready,
    output mem_rdvalid, mem_rdaddr, mem_rddata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  busy, done, tag_err,
    input  mem_rqvalid, mem_rqaddr, mem_wren, mem_addr, mem_wrdata
  );

endinterface

// File: rtl/mymem_rsp_fifo.sv
// Synchronous read-response buffer; push and pop may coincide in one cycle.
// Push when full and pop when empty are ignored.
module mymem_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [PTR_W:0]   count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers/count alone define validity, and
  // leaving the array unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mymem_burst_master.sv
// Burst master for the 1024x64 scratch memory: streams N words out as writes
// or issues N tagged reads, buffering responses since the memory cannot stall.
module mymem_burst_master
  import mymem_pkg::*;
#(
  parameter int ADDR_W     = MYMEM_ADDR_W,
  parameter int DATA_W     = MYMEM_DATA_W,
  parameter int TAG_W      = MYMEM_TAG_W,
  parameter int FIFO_DEPTH = MYMEM_FIFO_DEPTH
) (
  input logic                  clock,
  input logic                  reset_n,
  mymem_burst_master_if.master bus
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   returned_q, returned_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  exp_tag_q, exp_tag_d;
  logic              inflight_q, inflight_d;
  logic              tag_err_q, tag_err_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic              fifo_push, fifo_pop;
  logic [CNT_W:0]    occupancy;
  logic              credit;
  logic [ADDR_W:0]   issued_inc;
  logic [ADDR_W-1:0] word_addr;

  // A request issued last cycle has a FIFO slot reserved until it returns.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit     = (occupancy < DEPTH_C);
  assign issued_inc = issued_q + (ADDR_W+1)'(1);
  assign word_addr  = wrap_addr(cmd_q.base, issued_q[ADDR_W-1:0]);

  assign fifo_push    = bus.mem_rdvalid && !fifo_full;
  assign fifo_pop     = bus.rd_ready && !fifo_empty;
  assign bus.rd_valid = !fifo_empty;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.tag_err  = tag_err_q;

  mymem_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .push_i  (fifo_push),
    .wdata_i (bus.mem_rddata),
    .pop_i   (fifo_pop),
    .rdata_o (bus.rd_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    issued_d        = issued_q;
    returned_d      = returned_q;
    tag_d           = tag_q;
    exp_tag_d       = exp_tag_q;
    inflight_d      = 1'b0;
    tag_err_d       = tag_err_q;
    bus.cmd_ready   = 1'b0;
    bus.wr_ready    = 1'b0;
    bus.done        = 1'b0;
    bus.mem_rqvalid = 1'b0;
    bus.mem_rqaddr  = '0;
    bus.mem_wren    = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wrdata  = '0;

    case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cmd_d      = '{write: bus.cmd_write, base: bus.cmd_base, len: bus.cmd_len};
          issued_d   = '0;
          returned_d = '0;
          tag_d      = '0;
          exp_tag_d  = '0;
          tag_err_d  = 1'b0;
          if (bus.cmd_len == '0)  state_d = ST_FIN;
          else if (bus.cmd_write) state_d = ST_WRITE;
          else                    state_d = ST_READ;
        end
      end

      ST_WRITE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) begin
          bus.mem_wren   = 1'b1;
          bus.mem_addr   = word_addr;
          bus.mem_wrdata = bus.wr_data;
          issued_d       = issued_inc;
          if (issued_inc == cmd_q.len) state_d = ST_FIN;
        end
      end

      ST_READ: begin
        if (credit) begin
          bus.mem_rqvalid = 1'b1;
          bus.mem_rqaddr  = tag_q;
          bus.mem_addr    = word_addr;
          tag_d           = tag_q + TAG_W'(1);
          issued_d        = issued_inc;
          inflight_d      = 1'b1;
          if (issued_inc == cmd_q.len) state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if ((returned_q == cmd_q.len) && fifo_empty) state_d = ST_FIN;
      end

      ST_FIN: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Responses are checked in every state; a bad tag still lands in the FIFO.
    if (bus.mem_rdvalid) begin
      if (!inflight_q || (bus.mem_rdaddr != exp_tag_q)) tag_err_d = 1'b1;
      if (inflight_q) begin
        returned_d = returned_q + (ADDR_W+1)'(1);
        exp_tag_d  = exp_tag_q + TAG_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      tag_q      <= '0;
      exp_tag_q  <= '0;
      inflight_q <= 1'b0;
      tag_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      tag_q      <= tag_d;
      exp_tag_q  <= exp_tag_d;
      inflight_q <= inflight_d;
      tag_err_q  <= tag_err_d;
    end
  end

endmodule

// File: tb/tb_mymem_burst_master.sv
// Directed bench for mymem_burst_master with a one-cycle-latency memory model
// that can corrupt the tag of one chosen response.
module tb_mymem_burst_master;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  int   req_cnt;
  int   corrupt_idx = -1;
  logic [63:0] mem_model [1024];

  localparam logic [63:0] DA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DB = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DC = 64'h0F0F_F0F0_5A5A_A5A5;
  localparam logic [63:0] D0 = 64'hD000_0000_0000_0000;

  always #5 clock = ~clock;

  mymem_burst_master_if bus ();

  mymem_burst_master dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_rdvalid <= 1'b0;
      bus.mem_rdaddr  <= '0;
      bus.mem_rddata  <= '0;
      req_cnt         <= 0;
    end else begin
      bus.mem_rdvalid <= bus.mem_rqvalid;
      bus.mem_rdaddr  <= bus.mem_rqaddr ^ ((req_cnt == corrupt_idx) ? 5'd1 : 5'd0);
      bus.mem_rddata  <= mem_model[bus.mem_addr];
      if (bus.mem_rqvalid) req_cnt <= req_cnt + 1;
    end
  end

  always_ff @(posedge clock) begin
    if (bus.mem_wren) mem_model[bus.mem_addr] <= bus.mem_wrdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] wd [3];
    logic [9:0]  wrap_a [4];
    int n_done, n_iss, n_pop, n_rd, start_req, cyc;

    wd[0] = DA; wd[1] = DB; wd[2] = DC;
    wrap_a[0] = 10'd1022; wrap_a[1] = 10'd1023; wrap_a[2] = 10'd0; wrap_a[3] = 10'd1;

    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    // Reset state
    @(negedge clock); #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tag_err", bus.tag_err, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_mem_ctl", {bus.mem_rqvalid, bus.mem_wren, bus.mem_rqaddr}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wrdata", bus.mem_wrdata, 0);
    @(negedge clock); reset_n = 1'b1;

    // Write burst base=10 len=3
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_base = 10'd10; bus.cmd_len = 11'd3;
    bus.wr_valid = 1'b1; bus.wr_data = DA;
    #1;
    check("wr_accept_ready", bus.cmd_ready, 1);
    check("wr_idle_wr_ready", bus.wr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.cmd_valid = 1'b0; bus.wr_data = wd[i];
      #1;
      check("wr_wren", bus.mem_wren, 1);
      check("wr_rqvalid", bus.mem_rqvalid, 0);
      check("wr_addr", bus.mem_addr, 10 + i);
      check("wr_data", bus.mem_wrdata, wd[i]);
      check("wr_busy", bus.busy, 1);
    end
    @(negedge clock); bus.wr_valid = 1'b0; #1;
    check("wr_done", bus.done, 1);
    check("wr_fin_wren", bus.mem_wren, 0);
    check("wr_fin_busy", bus.busy, 1);
    @(negedge clock); #1;
    check("wr_done_clear", bus.done, 0);
    check("wr_idle_busy", bus.busy, 0);
    check("wr_idle_ready", bus.cmd_ready, 1);

    // Read burst base=10 len=3 with rd_ready high
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_base = 10'd10; bus.cmd_len = 11'd3;
    bus.rd_ready = 1'b1;
    @(negedge clock); bus.cmd_valid = 1'b0; #1;
    check("rd_rq0", {bus.mem_rqvalid, bus.mem_wren, bus.mem_rqaddr}, {1'b1, 1'b0, 5'd0});
    check("rd_addr0", bus.mem_addr, 10);
    check("rd_valid_early", bus.rd_valid, 0);
    @(negedge clock); #1;
    check("rd_rq1", {bus.mem_rqvalid, bus.mem_rqaddr}, {1'b1, 5'd1});
    check("rd_addr1", bus.mem_addr, 11);
    check("rd_valid_lat", bus.rd_valid, 0);
    @(negedge clock); #1;
    check("rd_rq2", {bus.mem_rqvalid, bus.mem_rqaddr}, {1'b1, 5'd2});
    check("rd_addr2", bus.mem_addr, 12);
    check("rd_valid0", bus.rd_valid, 1);
    check("rd_data0", bus.rd_data, DA);
    @(negedge clock); #1;
    check("rd_no_rq", bus.mem_rqvalid, 0);
    check("rd_data1", {bus.rd_valid, bus.rd_data}, {1'b1, DB});
    @(negedge clock); #1;
    check("rd_data2", {bus.rd_valid, bus.rd_data}, {1'b1, DC});
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); #1;
      if (bus.done) n_done++;
    end
    check("rd_done_once", n_done, 1);
    check("rd_tag_err", bus.tag_err, 0);

    // Wrapping write base=1022 len=4
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_base = 10'd1022; bus.cmd_len = 11'd4;
    bus.wr_valid = 1'b1; bus.wr_data = 64'h1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.cmd_valid = 1'b0; bus.wr_data = 64'h1000 + 64'(i);
      #1;
      check("wrap_addr", bus.mem_addr, wrap_a[i]);
      check("wrap_wren", bus.mem_wren, 1);
    end
    @(negedge clock); bus.wr_valid = 1'b0; #1;
    check("wrap_done", bus.done, 1);

    // Fill words 200..239 for the longer reads
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_base = 10'd200; bus.cmd_len = 11'd40;
    bus.wr_valid = 1'b1; bus.wr_data = D0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      bus.cmd_valid = 1'b0; bus.wr_data = D0 + 64'(i);
    end
    @(negedge clock); bus.wr_valid = 1'b0; #1;
    check("fill_done", bus.done, 1);

    // Read len=8 with consumer stalled: at most 4 requests before stall
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_base = 10'd200; bus.cmd_len = 11'd8;
    bus.rd_ready = 1'b0;
    #1; start_req = req_cnt;
    n_iss = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock); bus.cmd_valid = 1'b0; #1;
      if (bus.mem_rqvalid) n_iss++;
    end
    check("stall_issued", n_iss, 4);
    check("stall_head", {bus.rd_valid, bus.rd_data}, {1'b1, D0});
    check("stall_tag_err", bus.tag_err, 0);
    @(negedge clock); bus.rd_ready = 1'b1; #1;
    n_rd = 0; n_done = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (bus.rd_valid) begin
        check("stall_data", bus.rd_data, D0 + 64'(n_rd));
        n_rd++;
      end
      if (bus.done) n_done++;
      if (n_done != 0) break;
      @(negedge clock); #1;
    end
    check("stall_words", n_rd, 8);
    check("stall_done", n_done, 1);
    check("stall_total_req", req_cnt - start_req, 8);
    check("stall_no_err", bus.tag_err, 0);

    // Read len=40: tags wrap 31->0, one response tag corrupted
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_base = 10'd200; bus.cmd_len = 11'd40;
    #1; corrupt_idx = req_cnt + 35;
    n_iss = 0; n_pop = 0; n_done = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clock); bus.cmd_valid = 1'b0; #1;
      if (bus.mem_rqvalid) begin
        check("long_tag", bus.mem_rqaddr, 64'(n_iss % 32));
        check("long_addr", bus.mem_addr, 200 + n_iss);
        if (n_iss == 30) check("long_err_before", bus.tag_err, 0);
        n_iss++;
      end
      if (bus.rd_valid) begin
        check("long_data", bus.rd_data, D0 + 64'(n_pop));
        n_pop++;
      end
      if (bus.done) begin
        n_done++;
        break;
      end
    end
    check("long_issued", n_iss, 40);
    check("long_popped", n_pop, 40);
    check("long_done", n_done, 1);
    check("long_tag_err", bus.tag_err, 1);
    corrupt_idx = -1;
    @(negedge clock); #1;
    check("long_err_sticky", {bus.busy, bus.tag_err}, {1'b0, 1'b1});

    // len=0: done one cycle after accept, no memory traffic, tag_err cleared
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_base = 10'd5; bus.cmd_len = 11'd0;
    #1;
    check("zero_err_pre_accept", bus.tag_err, 1);
    @(negedge clock); bus.cmd_valid = 1'b0; #1;
    check("zero_done", bus.done, 1);
    check("zero_err_cleared", bus.tag_err, 0);
    check("zero_no_mem", {bus.mem_rqvalid, bus.mem_wren, bus.mem_addr}, 0);
    @(negedge clock); #1;
    check("zero_idle", {bus.done, bus.busy, bus.cmd_ready}, {1'b0, 1'b0, 1'b1});

    // Reset asserted mid-read
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_base = 10'd200; bus.cmd_len = 11'd8;
    @(negedge clock); bus.cmd_valid = 1'b0;
    @(negedge clock); #1;
    check("mid_issuing", bus.mem_rqvalid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_mem", {bus.mem_rqvalid, bus.mem_wren, bus.mem_rqaddr, bus.mem_addr}, 0);
    check("mid_rst_rd_valid", bus.rd_valid, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clock);
    @(negedge clock); reset_n = 1'b1; #1;
    n_done = 0; n_rd = 0; n_iss = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock); #1;
      if (bus.done) n_done++;
      if (bus.rd_valid) n_rd++;
      if (bus.mem_rqvalid) n_iss++;
    end
    check("post_rst_no_done", n_done, 0);
    check("post_rst_no_data", n_rd, 0);
    check("post_rst_no_req", n_iss, 0);
    check("post_rst_ready", {bus.cmd_ready, bus.busy, bus.tag_err}, {1'b1, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mymem_burst_master.md
Name: mymem_burst_master

Overview:
- Requester-side controller for the 1024x64 scratch memory's request/response interface.
- Accepts a burst command from the RoCC accelerator datapath: write N words from a stream, or read N words into a stream.
- Issues tagged per-word requests to the memory and checks returned tags. Buffers read responses, because the memory cannot be back-pressured.
- Sits between the accelerator command decoder and the memory.

Parameters:
- ADDR_W, 10, word-address width (memory depth 2^ADDR_W)
- DATA_W, 64, data word width
- TAG_W, 5, request tag width
- FIFO_DEPTH, 4, read-response buffer entries (power of 2, >= 2)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_base  in  ADDR_W  first word address
- cmd_len  in  ADDR_W+1  word count, 0..1024
- wr_valid  in  1  write-data stream valid
- wr_ready  out  1  write-data stream ready
- wr_data  in  DATA_W  write word
- rd_valid  out  1  read-data stream valid (FIFO head)
- rd_ready  in  1  consumer ready
- rd_data  out  DATA_W  read word
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- tag_err  out  1  sticky: response tag mismatch or unexpected response
- mem_rqvalid  out  1  read request (expects response)
- mem_rqaddr  out  TAG_W  request tag
- mem_wren  out  1  write enable
- mem_addr  out  ADDR_W  word address
- mem_wrdata  out  DATA_W  write data
- mem_rdvalid  in  1  response valid (exactly 1 cycle after mem_rqvalid)
- mem_rdaddr  in  TAG_W  response tag
- mem_rddata  in  DATA_W  response data

Behaviour:
- Reset (async assert, sync deassert by system): state IDLE, all counters 0, FIFO empty.
  - Outputs: busy=0, done=0, tag_err=0, all mem_* = 0, rd_valid=0, wr_ready=0, cmd_ready=1.
  - Reset mid-burst abandons the burst; no done pulse; in-flight responses are lost.
- States: IDLE, WRITE, READ, DRAIN, FIN.
- IDLE: cmd_ready=1. On accept, latch base/len/dir, clear tag_err, clear issue and return counters, tag counter := 0.
  - len==0 -> FIN.
  - write -> WRITE; read -> READ.
- WRITE: wr_ready=1.
  - Each wr_valid&wr_ready cycle drives, combinationally that cycle: mem_wren=1, mem_addr=base+issued (mod 2^ADDR_W, wraps 1023->0), mem_wrdata=wr_data. mem_rqvalid stays 0.
  - After the len-th word -> FIN. No responses are expected.
- READ: issue one request per cycle while credit available.
  - Credit rule: fifo_count + inflight < FIFO_DEPTH, where inflight = requests issued last cycle not yet returned (0 or 1).
  - Request: mem_rqvalid=1, mem_wren=0, mem_addr=base+issued (wraps), mem_rqaddr=tag. Tag increments mod 2^TAG_W per request.
  - After the len-th issue -> DRAIN.
- Response handling, in any state:
  - mem_rdvalid pushes mem_rddata into the FIFO.
  - If mem_rdaddr != expected return tag, or no request is outstanding, set tag_err. Data is still pushed when space allows; never overflow.
- DRAIN: issue nothing; -> FIN when returned==len and FIFO empty (all words popped).
- FIN: done=1 for exactly one cycle, busy=0 next -> IDLE.
- busy=1 in WRITE/READ/DRAIN/FIN.
- rd_valid = FIFO non-empty; pop on rd_valid&rd_ready. Simultaneous push and pop in the same cycle is legal; count unchanged.
- Throughput: 1 word/cycle in both directions with rd_ready held high. Read latency from issue to rd_valid is 2 cycles (1 memory + 1 FIFO write).
- mem_* outputs are 0 whenever no request is issued that cycle.

Decomposition:
- Package mymem_pkg:
  - ADDR_W/DATA_W/TAG_W defaults
  - state enum (IDLE, WRITE, READ, DRAIN, FIN)
  - command struct {write, base, len}
- Sub-module mymem_rsp_fifo: synchronous FIFO, depth FIFO_DEPTH, push/pop/count/empty/full, async active-low reset.

Test Plan:
- Write burst base=10, len=3, data A,B,C, wr_valid held high -> mem_wren on 3 consecutive cycles at addr 10,11,12 with A,B,C; mem_rqvalid=0; done pulse the following cycle.
- Read burst base=10, len=3, rd_ready=1, memory model returns tag+data -> rqaddr tags 0,1,2; rd_data A,B,C each 2 cycles after its issue; done once; tag_err=0.
- Read len=8 with rd_ready=0 until cycle 20 -> at most FIFO_DEPTH(4) requests issued before stall; no FIFO overflow; all 8 words delivered in order once rd_ready=1.
- Wrap: write base=1022, len=4 -> addresses 1022,1023,0,1.
- Read len=40 -> tags wrap 31->0. Corrupt one response tag -> tag_err=1 and stays 1 until the next cmd accept.
- len=0 -> done one cycle after accept with no mem traffic. reset_n pulsed low mid-read-burst -> all outputs zero immediately, cmd_ready=1 after release, no done.
